// File: rtl/block_serial_subtractor_pkg.sv
// Shared types and sizing helpers for the block-serial subtractor.
package block_serial_subtractor_pkg;

  // Controller states: waiting for a request, stepping blocks, presenting result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of N-bit blocks in a W-bit operand.
  function automatic int calc_m(input int w, input int n);
    return w / n;
  endfunction

  // Block counter width: $clog2(M) bits, never narrower than one bit.
  function automatic int cnt_w(input int m);
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/block_serial_subtractor_if.sv
// Request/result bundle for the block-serial subtractor.
//
// Handshake: a request is taken on a rising edge where start = 1 and ready = 1;
// start while ready = 0 is dropped, not queued. The result has no back-pressure:
// done pulses for one cycle and diff/bout/ovf hold until the next done.
interface block_serial_subtractor_if #(
  parameter int W = 32
);
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;
  logic         done;

  modport master (
    output start, a, b, bin,
    input  ready, diff, bout, ovf, done
  );

  modport slave (
    input  start, a, b, bin,
    output ready, diff, bout, ovf, done
  );
endinterface

// File: rtl/block_subtract_bypass.sv
// Combinational N-bit block subtractor with borrow bypass.
module block_subtract_bypass #(
  parameter int N = 4
) (
  input  logic [N-1:0] a_k,
  input  logic [N-1:0] b_k,
  input  logic         bin,
  output logic [N-1:0] diff_k,
  output logic         bout
);

  logic ripple_br;

  // Bit-ripple borrow chain across the block, LSB first.
  always_comb begin
    ripple_br = bin;
    diff_k    = '0;
    for (int i = 0; i < N; i++) begin
      diff_k[i] = a_k[i] ^ b_k[i] ^ ripple_br;
      ripple_br = (~a_k[i] & b_k[i]) | (~(a_k[i] ^ b_k[i]) & ripple_br);
    end
  end

  // Equal blocks pass the incoming borrow straight through.
  assign bout = (a_k == b_k) ? bin : ripple_br;

endmodule

// File: rtl/block_serial_subtractor.sv
// Block-serial subtractor: diff = a - b - bin, one N-bit block per clock, LSB first.
// Operands are captured into shift registers, so later input changes are ignored.
// Requires W > N (at least two blocks).
module block_serial_subtractor
  import block_serial_subtractor_pkg::*;
#(
  parameter int W = 32,
  parameter int N = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  block_serial_subtractor_if.slave      bus,
  output state_t                        state_dbg
);

  localparam int M  = calc_m(W, N);
  localparam int CW = cnt_w(M);

  state_t         state;
  logic [CW-1:0]  k;
  logic           br;
  logic [W-1:0]   a_sh;
  logic [W-1:0]   b_sh;
  logic [W-N-1:0] res;
  logic           a_msb;
  logic           b_msb;
  logic [W-1:0]   diff_r;
  logic           bout_r;
  logic           ovf_r;
  logic           done_r;

  logic [N-1:0]   blk_diff;
  logic           blk_bout;

  block_subtract_bypass #(.N(N)) u_blk (
    .a_k    (a_sh[N-1:0]),
    .b_k    (b_sh[N-1:0]),
    .bin    (br),
    .diff_k (blk_diff),
    .bout   (blk_bout)
  );

  // Controller, operand shifters, result assembly and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      k      <= '0;
      br     <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      res    <= '0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      diff_r <= '0;
      bout_r <= 1'b0;
      ovf_r  <= 1'b0;
      done_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            br    <= bus.bin;
            a_msb <= bus.a[W-1];
            b_msb <= bus.b[W-1];
            k     <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh <= a_sh >> N;
          b_sh <= b_sh >> N;
          br   <= blk_bout;
          k    <= k + CW'(1);
          if (k == CW'(M - 1)) begin
            // Last block: the full result is this block on top of the stored ones.
            diff_r <= {blk_diff, res};
            bout_r <= blk_bout;
            ovf_r  <= (a_msb != b_msb) && (blk_diff[N-1] != a_msb);
            done_r <= 1'b1;
            state  <= DONE;
          end else begin
            res <= {blk_diff, res[W-N-1:N]};
          end
        end
        DONE: begin
          done_r <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          done_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready = (state == IDLE);
  assign bus.diff  = diff_r;
  assign bus.bout  = bout_r;
  assign bus.ovf   = ovf_r;
  assign bus.done  = done_r;
  assign state_dbg = state;

endmodule

// File: tb/tb_block_serial_subtractor.sv
// Directed bench for block_serial_subtractor (W=32, N=4): driver tasks push
// expected results; a monitor pops and compares on every done pulse.
module tb_block_serial_subtractor;
  import block_serial_subtractor_pkg::*;

  localparam int W = 32;
  localparam int N = 4;
  localparam int M = W / N;

  logic clk;
  logic rst;
  state_t state_dbg;

  block_serial_subtractor_if #(.W(W)) bus ();

  block_serial_subtractor #(.W(W), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: {bout, ovf, diff} plus the cycle count right after the accept edge.
  logic [W+1:0] exp_q[$];
  int           lat_q[$];
  int           checks = 0;
  int           errors = 0;

  // Monitor: compare every done pulse against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got diff=%h bout=%0b ovf=%0b, required no done",
                 bus.diff, bus.bout, bus.ovf);
      end else begin
        logic [W+1:0] e;
        int           l;
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        if ({bus.bout, bus.ovf, bus.diff} !== e) begin
          errors++;
          $display("FAIL result: got diff=%h bout=%0b ovf=%0b, required diff=%h bout=%0b ovf=%0b",
                   bus.diff, bus.bout, bus.ovf, e[W-1:0], e[W+1], e[W]);
        end
        checks++;
        if (cyc - l != M) begin
          errors++;
          $display("FAIL latency: got %0d cycles, required %0d", cyc - l, M);
        end
      end
    end
  end

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  // Wait (bounded) for a negedge with ready high.
  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!bus.ready) begin
      errors++;
      $display("FAIL ready_timeout: got ready=0, required 1");
    end
  endtask

  // Issue one request; returns just after the accepting edge with operands scrambled.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                       input logic [W-1:0] ed, input logic eb, input logic eo, input bit push);
    wait_ready();
    bus.a     = ta;
    bus.b     = tb_v;
    bus.bin   = tbin;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    if (push) begin
      exp_q.push_back({eb, eo, ed});
      lat_q.push_back(cyc);
    end
    bus.a   = $urandom();
    bus.b   = $urandom();
    bus.bin = 1'($urandom_range(0, 1));
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;
    rst       = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check("reset_ready", W'(bus.ready), W'(1));
    check("reset_done",  W'(bus.done),  W'(0));
    check("reset_diff",  bus.diff,      '0);
    check("reset_flags", W'({bus.bout, bus.ovf}), W'(0));
    check("reset_state", W'(state_dbg), W'(IDLE));

    // Directed arithmetic vectors.
    do_op(32'd100,        32'd58,         1'b0, 32'd42,         1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("run_ready_low", W'(bus.ready), W'(0));
    do_op(32'd0,          32'd1,          1'b0, 32'hFFFF_FFFF,  1'b1, 1'b0, 1'b1);
    do_op(32'h8000_0000,  32'd1,          1'b0, 32'h7FFF_FFFF,  1'b0, 1'b1, 1'b1);
    do_op(32'h7FFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'h8000_0000,  1'b1, 1'b1, 1'b1);
    do_op(32'h1234_5678,  32'h1234_5678,  1'b1, 32'hFFFF_FFFF,  1'b1, 1'b0, 1'b1);

    // Result holds after done while inputs wander.
    wait_ready();
    repeat (4) @(negedge clk);
    check("hold_diff", bus.diff, 32'hFFFF_FFFF);
    check("hold_flags", W'({bus.bout, bus.ovf}), W'(2'b10));

    // Start during RUN is ignored; next op goes back-to-back after done.
    do_op(32'd1000,       32'd1,          1'b0, 32'd999,        1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check("ignored_start_ready", W'(bus.ready), W'(0));
    bus.a     = 32'd5;
    bus.b     = 32'd3;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    do_op(32'h0000_0010,  32'h0000_0020,  1'b1, 32'hFFFF_FFEF,  1'b1, 1'b0, 1'b1);
    do_op(32'd5,          32'd3,          1'b1, 32'd1,          1'b0, 1'b0, 1'b1);

    // Reset at RUN cycle 4 aborts the operation.
    do_op(32'd77,         32'd7,          1'b0, 32'd70,         1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", W'(bus.ready), W'(1));
    check("abort_done",  W'(bus.done),  W'(0));
    check("abort_diff",  bus.diff,      '0);
    check("abort_state", W'(state_dbg), W'(IDLE));
    repeat (12) @(negedge clk);

    // Reset wins over a simultaneous start.
    bus.a     = 32'd9;
    bus.b     = 32'd4;
    bus.start = 1'b1;
    rst       = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;
    check("rst_prio_state", W'(state_dbg), W'(IDLE));
    repeat (12) @(negedge clk);
    check("rst_prio_diff", bus.diff, '0);

    // Recovery after reset.
    do_op(32'd9,          32'd4,          1'b0, 32'd5,          1'b0, 1'b0, 1'b1);

    // Drain the scoreboard.
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending results, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/block_serial_subtractor.md
BLOCK_SERIAL_SUBTRACTOR -- requirements
Module: block_serial_subtractor

Interface
REQ-001 Parameter W, default 32: operand and result width in bits.
REQ-002 Parameter N, default 4: block width in bits; W SHALL be an integer multiple of N, N >= 2; M = W/N blocks.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request; accepted only in a cycle where ready = 1.
REQ-006 a  input  W  minuend, two's complement signed.
REQ-007 b  input  W  subtrahend, two's complement signed.
REQ-008 bin  input  1  borrow-in.
REQ-009 ready  output  1  high when idle and able to accept start.
REQ-010 diff  output  W  result a - b - bin, modulo 2^W.
REQ-011 bout  output  1  unsigned borrow-out of the MSB block.
REQ-012 ovf  output  1  signed overflow flag.
REQ-013 done  output  1  one-cycle pulse; diff, bout and ovf are valid from this cycle.

Function
REQ-014 States SHALL be IDLE, RUN and DONE; ready = 1 only in IDLE.
REQ-015 IDLE with start = 1 at an edge SHALL capture a, b and bin, clear the block counter k, and move to RUN.
REQ-016 Each RUN edge SHALL process block k (LSB first): block diff = a_k - b_k - br, borrow register br <- block borrow-out, k <- k + 1.
REQ-017 Block borrow-out SHALL use bypass: if a_k == b_k on every bit, borrow-out = borrow-in; otherwise the bit-ripple borrow.
REQ-018 At the edge that processes block M-1, the state SHALL go to DONE and diff, bout and ovf SHALL be loaded.
REQ-019 done SHALL be 1 for exactly the single cycle spent in DONE; the next edge SHALL return to IDLE.
REQ-020 Latency: start accepted at edge e0 -> done high in the cycle after edge eM; ready high again after edge eM+1.
REQ-021 ovf = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]), using the captured operands.
REQ-022 diff, bout and ovf SHALL hold their values from DONE until the next DONE; changes to a, b or bin after capture SHALL have no effect.
REQ-023 start SHALL be ignored in RUN and DONE: no recapture, no restart.
REQ-024 Back-to-back operation: start in the first IDLE cycle after DONE SHALL be accepted.
REQ-025 Counter width SHALL be $clog2(M) bits, minimum 1; no wrap occurs, since the transition fires at k = M-1.

Reset
REQ-026 When rst = 1 at an edge: state <- IDLE, ready = 1, done = 0, diff = 0, bout = 0, ovf = 0, k = 0, br = 0.
REQ-027 rst SHALL take priority over start; start in a reset cycle SHALL be dropped.
REQ-028 Reset mid-RUN or in DONE SHALL abort the operation; no done pulse SHALL follow.

Structure
REQ-029 A shared package SHALL hold the state enum (IDLE, RUN, DONE) and the helper for M and the counter width.
REQ-030 One sub-module, block_subtract_bypass, SHALL hold the combinational N-bit block: inputs a_k, b_k and borrow-in; outputs diff_k and borrow-out with bypass; it is instantiated once.
REQ-031 Operands SHALL be held in shift registers (or indexed by k) and the result assembled in a working register; no combinational path from a or b to the outputs.

Verification (W=32, N=4)
REQ-032 a=100, b=58, bin=0 -> diff=42, bout=0, ovf=0; done exactly 8 cycles after the start edge.
REQ-033 a=0, b=1, bin=0 -> diff=0xFFFFFFFF, bout=1, ovf=0.
REQ-034 a=0x80000000, b=1, bin=0 -> diff=0x7FFFFFFF, ovf=1, bout=0; a=0x7FFFFFFF, b=0xFFFFFFFF -> diff=0x80000000, ovf=1.
REQ-035 a=b=0x12345678, bin=1 (all blocks bypass) -> diff=0xFFFFFFFF, bout=1, ovf=0.
REQ-036 start pulsed in RUN with different operands -> ignored; result is the first operation's; a second start in the cycle after done -> accepted, correct result.
REQ-037 rst asserted at RUN cycle 4 -> next cycle ready=1, done=0, diff=0; no done pulse until a new start.
